// File: rtl/instr_sequencer_if.sv
// Bus between the instruction sequencer and its environment: the program ROM,
// the per-opcode execution units and the run control.
interface instr_sequencer_if #(
  parameter int PC_W = 8
);
  logic            run;
  logic [15:0]     romData;
  logic [15:0]     doneIn;
  logic            pcIncIn;
  logic [PC_W-1:0] pc;
  logic [15:0]     instrOut;
  logic            busy;
  logic            halted;
  logic            fault;
  logic [1:0]      faultCode;

  modport master (
    input  run, romData, doneIn, pcIncIn,
    output pc, instrOut, busy, halted, fault, faultCode
  );

  modport slave (
    output run, romData, doneIn, pcIncIn,
    input  pc, instrOut, busy, halted, fault, faultCode
  );
endinterface

// File: rtl/instr_sequencer.sv
// Fetch/dispatch controller: owns PC and IR, broadcasts each instruction to the
// execution units, waits for the selected done under a watchdog, then retires.
module instr_sequencer #(
  parameter int          PC_W      = 8,
  parameter int          TIMEOUT   = 15,
  parameter logic [15:0] VALID_OPS = 16'h001E
) (
  input logic              clk,
  input logic              rst,
  instr_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_EXEC, S_RETIRE, S_HALT, S_FAULT
  } state_t;

  localparam logic [PC_W-1:0] PC_ONE    = PC_W'(1);
  localparam logic [7:0]      WDOG_LAST = 8'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic [15:0]     instr_out_q, instr_out_d;
  logic [7:0]      wdog_q, wdog_d;
  logic            inc_taken_q, inc_taken_d;
  logic            busy_q, busy_d;
  logic            halted_q, halted_d;
  logic            fault_q, fault_d;
  logic [1:0]      fault_code_q, fault_code_d;
  logic [3:0]      load_op;
  logic [3:0]      exec_op;

  assign load_op = bus.romData[15:12];
  assign exec_op = ir_q[15:12];

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    wdog_d       = wdog_q;
    inc_taken_d  = inc_taken_q;
    fault_code_d = fault_code_q;

    case (state_q)
      S_IDLE:  if (bus.run) state_d = S_FETCH;
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        ir_d   = bus.romData;
        wdog_d = '0;
        if (load_op == 4'h0)        state_d = S_RETIRE;
        else if (load_op == 4'hF)   state_d = S_HALT;
        else if (VALID_OPS[load_op]) state_d = S_EXEC;
        else begin
          state_d      = S_FAULT;
          fault_code_d = 2'b01;
        end
      end
      S_EXEC: begin
        // Only the first pcInc pulse of an instruction moves the PC.
        if (bus.pcIncIn && !inc_taken_q) begin
          pc_d        = pc_q + PC_ONE;
          inc_taken_d = 1'b1;
        end
        if (bus.doneIn[exec_op]) state_d = S_RETIRE;
        else if (wdog_q == WDOG_LAST) begin
          state_d      = S_FAULT;
          fault_code_d = 2'b10;
        end else wdog_d = wdog_q + 8'd1;
      end
      S_RETIRE: begin
        if (!inc_taken_q) pc_d = pc_q + PC_ONE;
        inc_taken_d = 1'b0;
        state_d     = bus.run ? S_FETCH : S_IDLE;
      end
      default: state_d = state_q;
    endcase

    // Outputs are computed from the next state so they come straight off flops.
    instr_out_d = (state_d == S_EXEC) ? ir_d : 16'h0000;
    busy_d      = (state_d == S_FETCH) || (state_d == S_LOAD) ||
                  (state_d == S_EXEC)  || (state_d == S_RETIRE);
    halted_d    = (state_d == S_HALT);
    fault_d     = (state_d == S_FAULT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      ir_q         <= '0;
      instr_out_q  <= '0;
      wdog_q       <= '0;
      inc_taken_q  <= 1'b0;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      instr_out_q  <= instr_out_d;
      wdog_q       <= wdog_d;
      inc_taken_q  <= inc_taken_d;
      busy_q       <= busy_d;
      halted_q     <= halted_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.instrOut  = instr_out_q;
  assign bus.busy      = busy_q;
  assign bus.halted    = halted_q;
  assign bus.fault     = fault_q;
  assign bus.faultCode = fault_code_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: ROM and execution-unit models around the DUT, with
// a per-cycle expected trace derived from the instruction timing rules.
module tb_instr_sequencer;

  localparam int PC_W    = 8;
  localparam int TIMEOUT = 15;

  typedef struct packed {
    logic [7:0]  pc;
    logic [15:0] instr;
    logic        busy;
    logic        halted;
    logic        fault;
    logic [1:0]  code;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] rom [256];
  logic [15:0] valid_ops = 16'h001E;

  // Unit behaviour: done / first pcInc / extra pcInc, as EXEC cycle numbers (0 = never).
  logic use_fields;
  int   cfg_done, cfg_inc, cfg_extra;
  logic stray_inc;
  int   unit_cnt;
  int   cur_done, cur_inc, cur_extra;
  logic [3:0] cur_op;

  obs_t exp_q[$];
  int   stop_idx;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  instr_sequencer_if #(.PC_W(PC_W)) bus ();

  instr_sequencer #(
    .PC_W(PC_W), .TIMEOUT(TIMEOUT), .VALID_OPS(16'h001E)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always @(posedge clk) bus.romData <= rom[bus.pc];

  always @(posedge clk or negedge rst) begin
    if (!rst) unit_cnt <= 0;
    else if (bus.instrOut != 16'h0000) unit_cnt <= unit_cnt + 1;
    else unit_cnt <= 0;
  end

  always_comb begin
    cur_op    = bus.instrOut[15:12];
    cur_done  = use_fields ? int'(bus.instrOut[7:4])  : cfg_done;
    cur_inc   = use_fields ? int'(bus.instrOut[3:0])  : cfg_inc;
    cur_extra = use_fields ? int'(bus.instrOut[11:8]) : cfg_extra;
    bus.doneIn  = 16'h0000;
    bus.pcIncIn = 1'b0;
    if (bus.instrOut != 16'h0000) begin
      if (unit_cnt == 0) bus.doneIn[cur_op ^ 4'h1] = 1'b1;
      if (cur_done != 0 && unit_cnt == cur_done - 1) bus.doneIn[cur_op] = 1'b1;
      if ((cur_inc != 0 && unit_cnt == cur_inc - 1) ||
          (cur_extra != 0 && unit_cnt == cur_extra - 1)) bus.pcIncIn = 1'b1;
    end else begin
      bus.pcIncIn = stray_inc;
    end
  end

  function automatic obs_t sample();
    obs_t o;
    o.pc     = bus.pc;
    o.instr  = bus.instrOut;
    o.busy   = bus.busy;
    o.halted = bus.halted;
    o.fault  = bus.fault;
    o.code   = bus.faultCode;
    return o;
  endfunction

  function automatic obs_t mk(int pc, logic [15:0] instr, logic busy, logic halted,
                              logic fault, logic [1:0] code);
    obs_t o;
    o.pc = 8'(pc); o.instr = instr; o.busy = busy;
    o.halted = halted; o.fault = fault; o.code = code;
    return o;
  endfunction

  task automatic checkOutput(input string tag, input obs_t got, input obs_t want);
    n_checks++;
    assert (got === want) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed pc=%0h instr=%h busy=%b halted=%b fault=%b code=%b, expected pc=%0h instr=%h busy=%b halted=%b fault=%b code=%b",
             tag, got.pc, got.instr, got.busy, got.halted, got.fault, got.code,
             want.pc, want.instr, want.busy, want.halted, want.fault, want.code);
    end
  endtask

  // Expected trace: FETCH, LOAD, N EXEC cycles, RETIRE; one PC step per instruction.
  task automatic build_trace(input int n_instr);
    int a, d, i, e, n, first_inc, pc_after;
    logic [15:0] w;
    logic [3:0]  op;
    exp_q.delete();
    stop_idx = -1;
    a = 0;
    for (int k = 0; k < n_instr; k++) begin
      w  = rom[a];
      op = w[15:12];
      exp_q.push_back(mk(a, 16'h0, 1, 0, 0, 2'b00));
      exp_q.push_back(mk(a, 16'h0, 1, 0, 0, 2'b00));
      if (k == n_instr - 1) stop_idx = exp_q.size();
      if (op == 4'h0) begin
        exp_q.push_back(mk(a, 16'h0, 1, 0, 0, 2'b00));
        a = (a + 1) % 256;
        continue;
      end
      if (op == 4'hF) begin
        repeat (4) exp_q.push_back(mk(a, 16'h0, 0, 1, 0, 2'b00));
        return;
      end
      if (!valid_ops[op]) begin
        repeat (4) exp_q.push_back(mk(a, 16'h0, 0, 0, 1, 2'b01));
        return;
      end
      d = use_fields ? int'(w[7:4])  : cfg_done;
      i = use_fields ? int'(w[3:0])  : cfg_inc;
      e = use_fields ? int'(w[11:8]) : cfg_extra;
      n = (d >= 1 && d <= TIMEOUT) ? d : TIMEOUT;
      first_inc = 0;
      if (i >= 1 && i <= n) first_inc = i;
      if (e >= 1 && e <= n && (first_inc == 0 || e < first_inc)) first_inc = e;
      for (int c = 1; c <= n; c++)
        exp_q.push_back(mk((first_inc != 0 && c > first_inc) ? (a + 1) % 256 : a,
                           w, 1, 0, 0, 2'b00));
      pc_after = (first_inc != 0) ? (a + 1) % 256 : a;
      if (!(d >= 1 && d <= TIMEOUT)) begin
        repeat (4) exp_q.push_back(mk(pc_after, 16'h0, 0, 0, 1, 2'b10));
        return;
      end
      exp_q.push_back(mk(pc_after, 16'h0, 1, 0, 0, 2'b00));
      a = (a + 1) % 256;
    end
    repeat (3) exp_q.push_back(mk(a, 16'h0, 0, 0, 0, 2'b00));
  endtask

  task automatic applyStimulus(input string tag, input bit rand_stray);
    rst = 1'b0; bus.run = 1'b1; stray_inc = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk); @(negedge clk);
      checkOutput($sformatf("%s_c%0d", tag, i), sample(), exp_q[i]);
      if (i == stop_idx) bus.run = 1'b0;
      if (rand_stray) stray_inc = 1'($urandom_range(0, 1));
    end
    stray_inc = 1'b0;
  endtask

  task automatic clear_rom();
    for (int k = 0; k < 256; k++) rom[k] = 16'h0000;
  endtask

  initial begin
    bit   found;
    int   len;
    logic [3:0] op;
    rst = 1'b0; bus.run = 1'b0; stray_inc = 1'b0;
    use_fields = 1'b0; cfg_done = 4; cfg_inc = 1; cfg_extra = 3;
    clear_rom();

    // Reset state, then asynchronous reset in the middle of a MOV.
    rom[0] = 16'h4041; rom[1] = 16'hF000;
    bus.run = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_state", sample(), '0);
    rst = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (bus.instrOut != 16'h0000) found = 1'b1;
    end
    checkOutput("mid_exec_reached", sample(), mk(0, 16'h4041, 1, 0, 0, 2'b00));
    #2 rst = 1'b0;
    #1 checkOutput("reset_async", sample(), '0);
    @(posedge clk); #1 checkOutput("reset_hold", sample(), '0);

    // Two MOVs (7 cycles each, one PC step each, extra pcInc ignored) then HALT.
    clear_rom();
    rom[0] = 16'h4041; rom[1] = 16'h4082; rom[2] = 16'hF000;
    build_trace(10);
    applyStimulus("mov", 1'b0);

    // NOP then HALT; run toggling while halted has no effect.
    clear_rom();
    rom[0] = 16'h0000; rom[1] = 16'hF000;
    build_trace(10);
    applyStimulus("nop_halt", 1'b1);
    for (int c = 0; c < 4; c++) begin
      bus.run = c[0];
      @(posedge clk); @(negedge clk);
      checkOutput("halt_sticky", sample(), mk(1, 16'h0, 0, 1, 0, 2'b00));
    end

    // Illegal opcode.
    clear_rom();
    rom[0] = 16'h9000;
    build_trace(10);
    applyStimulus("illegal", 1'b0);

    // Watchdog: unit never done, then done exactly on the last allowed cycle.
    clear_rom();
    rom[0] = 16'h1000; rom[1] = 16'hF000;
    cfg_done = 0; cfg_inc = 0; cfg_extra = 0;
    build_trace(10);
    applyStimulus("wdog_fault", 1'b0);
    cfg_done = 15; cfg_inc = 0; cfg_extra = 0;
    build_trace(10);
    applyStimulus("wdog_edge", 1'b0);

    // PC wrap over 258 NOPs, run dropped during the last one.
    clear_rom();
    build_trace(258);
    applyStimulus("wrap", 1'b1);

    // Run dropped mid-EXEC: instruction completes, then IDLE.
    rom[0] = 16'h4041;
    cfg_done = 4; cfg_inc = 1; cfg_extra = 3;
    build_trace(1);
    applyStimulus("run_drop", 1'b0);

    // Random programs; each word's low bits describe its unit's timing.
    use_fields = 1'b1;
    for (int p = 0; p < 4; p++) begin
      clear_rom();
      len = $urandom_range(6, 14);
      for (int k = 0; k < len; k++) begin
        op = 4'($urandom_range(0, 4));
        if (op == 4'h0) rom[k] = 16'h0000;
        else rom[k] = {op, 4'($urandom_range(0, 15)), 4'($urandom_range(1, 15)),
                       4'($urandom_range(0, 15))};
      end
      rom[len] = 16'hF000;
      build_trace(100);
      applyStimulus($sformatf("rand%0d", p), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Fetch/dispatch controller for the microcontroller's execution units. It owns the program counter and the instruction register, fetches 16-bit words from the synchronous program ROM, and broadcasts each instruction to the per-opcode execution FSMs (MOV, etc.). It waits for the selected unit's `done`, guards each instruction with a watchdog, and inserts a NOP cycle between instructions so that every opcode-gated unit returns to its idle state.

## Interface
- `PC_W`, 8: program counter width.
- `TIMEOUT`, 15: max EXEC cycles without `done` before fault (1..255).
- `VALID_OPS`, 16'h001E: bit n set = opcode n is served by an execution unit.

- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `run` in 1: enable; sampled in IDLE and RETIRE.
- `romData` in 16: ROM word at `pc`, valid one cycle after `pc` is driven.
- `doneIn` in 16: per-opcode done, bit n from the unit for opcode n (unused bits tied 0).
- `pcIncIn` in 1: OR of the units' `pcInc` outputs.
- `pc` out PC_W: program counter / ROM address.
- `instrOut` out 16: instruction broadcast to the units; 16'h0000 (NOP) whenever not in EXEC.
- `busy` out 1: high in FETCH, LOAD, EXEC, RETIRE.
- `halted` out 1: high in HALT.
- `fault` out 1: high in FAULT.
- `faultCode` out 2: 01 illegal opcode, 10 watchdog timeout, 00 otherwise.

## Operation
- Registered state, one-hot or binary: IDLE, FETCH, LOAD, EXEC, RETIRE, HALT, FAULT.
- IDLE: `run`=1 -> FETCH.
- FETCH: `pc` is stable on the ROM address. Next -> LOAD.
- LOAD: IR <= `romData`, and the next state is decoded from `romData[15:12]`:
  - 4'h0 (NOP) -> RETIRE.
  - 4'hF -> HALT.
  - `VALID_OPS[op]`=1 -> EXEC.
  - Otherwise -> FAULT with `faultCode`=01.
- EXEC:
  - `instrOut`=IR; the watchdog counts from 0.
  - `doneIn[IR[15:12]]`=1 at an edge -> RETIRE. Other `doneIn` bits are ignored.
  - Watchdog reaches `TIMEOUT` without `done` -> FAULT with `faultCode`=10.
- PC increment rule: exactly one increment per instruction.
  - In EXEC, the first cycle with `pcIncIn`=1 increments `pc` and sets an inc-taken flag. Further `pcIncIn` pulses are ignored.
  - In RETIRE, `pc` increments only if the flag is clear (NOP, or a unit that never pulses). The flag clears in RETIRE.
- RETIRE: `instrOut`=0 for one cycle. `run`=1 -> FETCH, else -> IDLE.
- `run` dropping during FETCH, LOAD or EXEC does not abort; the current instruction completes.
- HALT and FAULT are sticky; only `rst` exits them. `instrOut`=0 and `pc` is frozen in both.
- `pc` arithmetic is modulo 2^PC_W: all-ones + 1 -> 0, with no flag.
- `pcIncIn` outside EXEC is ignored.

## Timing
- Reset (async assert, `rst`=0) forces:
  - state = IDLE.
  - `pc`, IR, `instrOut`, watchdog, inc flag = 0.
  - `busy`, `halted`, `fault` = 0; `faultCode` = 00.
- Reset release: sampled synchronously; the first transition happens at the first rising edge with `rst`=1.
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- Latency:
  - FETCH 1 cycle, LOAD 1 cycle, EXEC N cycles (N = cycles until `done` is sampled), RETIRE 1 cycle.
  - MOV (done 3 cycles after opcode seen) = 1+1+4+1 = 7 cycles per instruction.
  - NOP = 3 cycles. HALT is entered 2 cycles after FETCH.
- The NOP cycle in RETIRE guarantees a back-to-back identical opcode restarts its unit from idle.
- `doneIn` and the watchdog limit asserted in the same cycle: `done` wins, and the instruction retires.

## Test plan
- Reset mid-EXEC: assert `rst`=0 during a MOV -> all outputs zero immediately (no clock needed), state IDLE, `pc`=0.
- MOV sequence, ROM[0]=16'h4041, ROM[1]=16'h4082, MOV-unit model:
  - each instruction takes 7 cycles, with `instrOut`=0 in the RETIRE cycle;
  - `pc` goes 0 -> 1 at the first `pcInc`, then 1 -> 2, with one increment per instruction.
- NOP then HALT, ROM = {16'h0000, 16'hF000} -> `pc` 0 -> 1 after 3 cycles; `halted`=1 with `pc`=1 held; `run` toggling has no effect.
- Illegal opcode 16'h9000 with default `VALID_OPS` -> `fault`=1, `faultCode`=01, `instrOut` stays 0.
- Watchdog: a unit that never asserts `done` -> FAULT after exactly 15 EXEC cycles, `faultCode`=10. A variant with `done` in the 15th cycle retires normally.
- PC wrap: `PC_W`=8, NOPs everywhere, run 256 instructions -> `pc` wraps 255 -> 0. Dropping `run` mid-EXEC -> instruction completes, then IDLE with `busy`=0.
